// File: rtl/b_ram_access_ctrl_if.sv
// Bus bundle between the B RAM access controller and its fill/traceback clients.
// The master side drives requests and the slave side (the controller) answers.
interface b_ram_access_ctrl_if #(
    parameter int BitAddr = 8
);
    logic             start;
    logic             stall;
    logic             tb_req;
    logic [BitAddr:0] tb_j;
    logic             rd_en;
    logic [BitAddr:0] addr_B;
    logic             data_valid;
    logic [BitAddr:0] i_row;
    logic [BitAddr:0] j_col;
    logic             tb_gnt;
    logic             row_done;
    logic             fill_done;
    logic             trace_done;
    logic             err_range;
    logic             busy;

    modport master (
        output start, stall, tb_req, tb_j,
        input  rd_en, addr_B, data_valid, i_row, j_col, tb_gnt,
        input  row_done, fill_done, trace_done, err_range, busy
    );

    modport slave (
        input  start, stall, tb_req, tb_j,
        output rd_en, addr_B, data_valid, i_row, j_col, tb_gnt,
        output row_done, fill_done, trace_done, err_range, busy
    );
endinterface

// File: rtl/b_ram_access_ctrl.sv
// Sequences B RAM reads: a row-by-row fill pass over an N x N matrix, then
// traceback reads on request until the traceback reaches column 0.
module b_ram_access_ctrl #(
    parameter int N       = 128,
    parameter int BitAddr = $clog2(N + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    b_ram_access_ctrl_if.slave   bus
);
    typedef enum logic [2:0] {IDLE, FILL, ROW_END, TRACE, DONE} state_t;

    localparam logic [BitAddr:0] N_VAL = N[BitAddr:0];
    localparam logic [BitAddr:0] ONE   = {{BitAddr{1'b0}}, 1'b1};

    state_t           state_reg, state_next;
    logic [BitAddr:0] i_reg, i_next;
    logic [BitAddr:0] j_reg, j_next;
    logic [BitAddr:0] addr_reg, addr_next;
    logic             rd_en_reg, rd_en_next;
    logic             gnt_reg, gnt_next;
    logic             row_done_reg, row_done_next;
    logic             fill_done_reg, fill_done_next;
    logic             trace_done_reg, trace_done_next;
    logic             err_reg, err_next;
    logic             dv_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            i_reg          <= '0;
            j_reg          <= '0;
            addr_reg       <= '0;
            rd_en_reg      <= 1'b0;
            gnt_reg        <= 1'b0;
            row_done_reg   <= 1'b0;
            fill_done_reg  <= 1'b0;
            trace_done_reg <= 1'b0;
            err_reg        <= 1'b0;
            dv_reg         <= 1'b0;
        end else begin
            state_reg      <= state_next;
            i_reg          <= i_next;
            j_reg          <= j_next;
            addr_reg       <= addr_next;
            rd_en_reg      <= rd_en_next;
            gnt_reg        <= gnt_next;
            row_done_reg   <= row_done_next;
            fill_done_reg  <= fill_done_next;
            trace_done_reg <= trace_done_next;
            err_reg        <= err_next;
            // RAM has one cycle of read latency
            dv_reg         <= rd_en_reg;
        end
    end

    always_comb begin
        state_next      = state_reg;
        i_next          = i_reg;
        j_next          = j_reg;
        rd_en_next      = 1'b0;
        addr_next       = '0;
        gnt_next        = 1'b0;
        row_done_next   = 1'b0;
        fill_done_next  = 1'b0;
        trace_done_next = 1'b0;
        err_next        = 1'b0;

        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    state_next = FILL;
                    i_next     = ONE;
                    j_next     = ONE;
                end
            end
            FILL: begin
                if (bus.stall) begin
                    // A stalled cycle keeps the last address on the bus
                    addr_next = addr_reg;
                end else begin
                    rd_en_next = 1'b1;
                    addr_next  = j_reg;
                    if (j_reg == N_VAL) state_next = ROW_END;
                    else                j_next     = j_reg + ONE;
                end
            end
            ROW_END: begin
                row_done_next = 1'b1;
                if (i_reg == N_VAL) begin
                    fill_done_next = 1'b1;
                    state_next     = TRACE;
                    i_next         = '0;
                    j_next         = '0;
                end else begin
                    i_next     = i_reg + ONE;
                    j_next     = ONE;
                    state_next = FILL;
                end
            end
            TRACE: begin
                if (bus.tb_req) begin
                    if (bus.tb_j == '0) begin
                        trace_done_next = 1'b1;
                        state_next      = DONE;
                    end else if (bus.tb_j > N_VAL) begin
                        err_next = 1'b1;
                    end else begin
                        rd_en_next = 1'b1;
                        addr_next  = bus.tb_j;
                        gnt_next   = 1'b1;
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign bus.rd_en      = rd_en_reg;
    assign bus.addr_B     = addr_reg;
    assign bus.data_valid = dv_reg;
    assign bus.i_row      = i_reg;
    assign bus.j_col      = j_reg;
    assign bus.tb_gnt     = gnt_reg;
    assign bus.row_done   = row_done_reg;
    assign bus.fill_done  = fill_done_reg;
    assign bus.trace_done = trace_done_reg;
    assign bus.err_range  = err_reg;
    assign bus.busy       = (state_reg != IDLE);
endmodule

// File: tb/tb_b_ram_access_ctrl.sv
// Randomised bench for b_ram_access_ctrl with N=4: fill passes (free-running,
// directed stall, random stall), traceback sequences and asynchronous reset.
module tb_b_ram_access_ctrl;
    localparam int N  = 4;
    localparam int BA = $clog2(N + 1);
    localparam int AW = BA + 1;
    localparam int W  = 3 * AW + 8;

    typedef logic [W-1:0] obs_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    bit   prev_rd;

    b_ram_access_ctrl_if #(.BitAddr(BA)) bus ();

    b_ram_access_ctrl #(.N(N), .BitAddr(BA)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    // Field order: rd,addr,gnt,row_done,fill_done,trace_done,err,busy,dv,i_row,j_col
    function automatic obs_t pack(input bit rd, input int addr, input bit gnt,
                                  input bit rowd, input bit filld, input bit traced,
                                  input bit err, input bit busy, input bit dv,
                                  input int i, input int j);
        return {rd, AW'(addr), gnt, rowd, filld, traced, err, busy, dv, AW'(i), AW'(j)};
    endfunction

    function automatic obs_t observe();
        return {bus.rd_en, bus.addr_B, bus.tb_gnt, bus.row_done, bus.fill_done,
                bus.trace_done, bus.err_range, bus.busy, bus.data_valid,
                bus.i_row, bus.j_col};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t got;
        bus.start = 0; bus.stall = 0; bus.tb_req = 0; bus.tb_j = '0;
        rst_n = 1'b0;
        #1;
        got = observe();
        checks++;
        if (got !== pack(0,0,0,0,0,0,0,0,0,0,0)) begin
            errors++;
            $display("FAIL reset_async: got %h required %h", got, pack(0,0,0,0,0,0,0,0,0,0,0));
        end
        step(); step();
        rst_n = 1'b1;
        step();
        got = observe();
        checks++;
        if (got !== pack(0,0,0,0,0,0,0,0,0,0,0)) begin
            errors++;
            $display("FAIL reset_idle: got %h required %h", got, pack(0,0,0,0,0,0,0,0,0,0,0));
        end
        prev_rd = 0;
    endtask

    // mode 0: no stall, 1: random stall, 2: three stall cycles at row 1 column 2
    task automatic test_fill(input int mode);
        obs_t got, exp;
        int   last_addr;
        bit   s;
        bus.stall = 0; bus.tb_req = 0;
        bus.start = 1;
        step();
        bus.start = 0;
        exp = pack(0,0,0,0,0,0,0,1,prev_rd,1,1);
        got = observe();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL fill_start mode=%0d: got %h required %h", mode, got, exp);
        end
        prev_rd   = 0;
        last_addr = 0;
        for (int i = 1; i <= N; i++) begin
            for (int j = 1; j <= N; j++) begin
                for (int g = 0; g < 20; g++) begin
                    case (mode)
                        1:       s = (g < 6) && ($urandom_range(0, 2) == 0);
                        2:       s = (i == 1) && (j == 2) && (g < 3);
                        default: s = 0;
                    endcase
                    bus.stall  = s;
                    bus.start  = $urandom_range(0, 1);
                    bus.tb_req = $urandom_range(0, 1);
                    bus.tb_j   = AW'($urandom_range(0, N + 2));
                    step();
                    if (s) begin
                        exp = pack(0,last_addr,0,0,0,0,0,1,prev_rd,i,j);
                    end else begin
                        exp = pack(1,j,0,0,0,0,0,1,prev_rd,i,(j == N) ? N : j + 1);
                        last_addr = j;
                    end
                    got = observe();
                    checks++;
                    if (got !== exp) begin
                        errors++;
                        $display("FAIL fill_read mode=%0d i=%0d j=%0d stall=%0d: got %h required %h",
                                 mode, i, j, s, got, exp);
                    end
                    prev_rd = !s;
                    if (!s) break;
                end
            end
            bus.stall  = $urandom_range(0, 1);
            bus.start  = $urandom_range(0, 1);
            bus.tb_req = $urandom_range(0, 1);
            step();
            exp = pack(0,0,0,1,(i == N),0,0,1,prev_rd,(i == N) ? 0 : i + 1,(i == N) ? 0 : 1);
            got = observe();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL fill_row_end mode=%0d i=%0d: got %h required %h", mode, i, got, exp);
            end
            prev_rd   = 0;
            last_addr = 0;
        end
        bus.stall = 0; bus.start = 0; bus.tb_req = 0;
    endtask

    // Directed column list followed by random requests, then end at column 0
    task automatic test_trace(input int n_random);
        obs_t got, exp;
        int   tj;
        bit   req;
        int   dir_j [3] = '{3, 2, N + 1};
        for (int k = 0; k < 3 + n_random; k++) begin
            if (k < 3) begin
                req = 1;
                tj  = dir_j[k];
            end else begin
                req = $urandom_range(0, 1);
                tj  = $urandom_range(1, N + 3);
            end
            bus.tb_req = req;
            bus.tb_j   = AW'(tj);
            bus.start  = $urandom_range(0, 1);
            step();
            if (req && tj <= N) exp = pack(1,tj,1,0,0,0,0,1,prev_rd,0,0);
            else if (req)       exp = pack(0,0,0,0,0,0,1,1,prev_rd,0,0);
            else                exp = pack(0,0,0,0,0,0,0,1,prev_rd,0,0);
            got = observe();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL trace_req k=%0d req=%0d tb_j=%0d: got %h required %h", k, req, tj, got, exp);
            end
            prev_rd = req && (tj <= N);
        end
        bus.start  = 0;
        bus.tb_req = 1;
        bus.tb_j   = '0;
        step();
        exp = pack(0,0,0,0,0,1,0,1,prev_rd,0,0);
        got = observe();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL trace_done: got %h required %h", got, exp);
        end
        bus.tb_req = 1;
        bus.tb_j   = AW'(2);
        step();
        exp = pack(0,0,0,0,0,0,0,0,0,0,0);
        got = observe();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL trace_to_idle: got %h required %h", got, exp);
        end
        step();
        got = observe();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL idle_ignores_tb_req: got %h required %h", got, exp);
        end
        bus.tb_req = 0;
        prev_rd    = 0;
    endtask

    task automatic test_reset_mid_fill();
        obs_t got, exp;
        bus.start = 1;
        step();
        bus.start = 0;
        for (int c = 0; c < N + 3; c++) step();
        exp = pack(1,2,0,0,0,0,0,1,1,2,3);
        got = observe();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL pre_abort_position: got %h required %h", got, exp);
        end
        #2;
        rst_n = 1'b0;
        #1;
        exp = pack(0,0,0,0,0,0,0,0,0,0,0);
        got = observe();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL abort_async_clear: got %h required %h", got, exp);
        end
        step(); step();
        got = observe();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL abort_no_done: got %h required %h", got, exp);
        end
        rst_n   = 1'b1;
        prev_rd = 0;
        step();
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        prev_rd = 0;
        test_reset();
        test_fill(0);
        test_trace(0);
        test_fill(2);
        test_trace(12);
        test_fill(1);
        test_trace(12);
        test_reset_mid_fill();
        test_fill(0);
        test_trace(6);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
